// File: rtl/apb_global_pkg.sv
// Shared APB definitions: default bus widths, transfer/error types and the
// responder FSM state encoding.
package apb_global_pkg;

    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 32;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } tx_type_e;

    typedef enum logic {
        NO_ERROR    = 1'b0,
        SLAVE_ERROR = 1'b1
    } slave_error_e;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT,
        ACCESS
    } apb_slave_state_e;

endpackage

// File: rtl/apb_slave_regfile.sv
// Register storage for the APB responder: byte-lane strobed writes and a
// combinational read mux.
module apb_slave_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NO_OF_REGS = 16,
    parameter int IDX_WIDTH  = (NO_OF_REGS > 1) ? $clog2(NO_OF_REGS) : 1
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    wr_en,
    input  logic [IDX_WIDTH-1:0]    wr_idx,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic [IDX_WIDTH-1:0]    rd_idx,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs [NO_OF_REGS];

    // NOTE: the array is cleared on reset on purpose, so it builds as
    // flops rather than RAM; software relies on reading zeros after reset.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int r = 0; r < NO_OF_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < LANES; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign rd_data = regs[rd_idx];

endmodule

// File: rtl/apb_slave_responder.sv
// APB slave responder: FSM with programmable wait states, address decode and
// error response. Define APB_SLAVE_PROT_CHECK_EN to make register 0 secure-only.
module apb_slave_responder #(
    parameter int                       ADDRESS_WIDTH = apb_global_pkg::ADDRESS_WIDTH,
    parameter int                       DATA_WIDTH    = apb_global_pkg::DATA_WIDTH,
    parameter int                       NO_OF_REGS    = 16,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = ADDRESS_WIDTH'(32'h0000_0000)
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     pselx,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [ADDRESS_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0]    pwdata,
    input  logic [DATA_WIDTH/8-1:0]  pstrb,
    input  logic [2:0]               pprot,
    input  logic [3:0]               cfg_wait_states,
    output logic                     pready,
    output logic                     pslverr,
    output logic [DATA_WIDTH-1:0]    prdata
);

    import apb_global_pkg::*;

    localparam int                       BYTES      = DATA_WIDTH / 8;
    localparam int                       OFFS_BITS  = $clog2(BYTES);
    localparam int                       IDX_WIDTH  = (NO_OF_REGS > 1) ? $clog2(NO_OF_REGS) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] REG_SPAN   = ADDRESS_WIDTH'(NO_OF_REGS * BYTES);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(BYTES - 1);

    apb_slave_state_e          state;
    apb_slave_state_e          next_state;
    logic [3:0]                wait_cnt;
    logic [ADDRESS_WIDTH-1:0]  lat_addr;
    tx_type_e                  lat_write;
    logic [DATA_WIDTH-1:0]     lat_wdata;
    logic [DATA_WIDTH/8-1:0]   lat_strb;
    logic [2:0]                lat_prot;

    logic [ADDRESS_WIDTH-1:0]  offset;
    logic                      in_range;
    logic                      aligned;
    logic [IDX_WIDTH-1:0]      reg_idx;
    slave_error_e              err;
    logic                      wr_en;
    logic [DATA_WIDTH-1:0]     rd_data;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of the order of statements.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (pselx && !penable) next_state = SETUP;
            end
            SETUP: begin
                if (!pselx)                         next_state = IDLE;
                else if (cfg_wait_states == 4'd0)   next_state = ACCESS;
                else                                next_state = WAIT;
            end
            WAIT: begin
                if (!pselx)                         next_state = IDLE;
                else if (penable && wait_cnt == 4'd1) next_state = ACCESS;
            end
            ACCESS: begin
                if (pselx && !penable) next_state = SETUP;
                else                   next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Transfer attributes are captured once in SETUP and held for the rest of
    // the transfer, so the master may change the bus during wait states.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_write <= READ;
            lat_wdata <= '0;
            lat_strb  <= '0;
            lat_prot  <= '0;
        end else if (state == SETUP && pselx) begin
            wait_cnt  <= cfg_wait_states;
            lat_addr  <= paddr;
            lat_write <= tx_type_e'(pwrite);
            lat_wdata <= pwdata;
            lat_strb  <= pstrb;
            lat_prot  <= pprot;
        end else if (state == WAIT && pselx && penable) begin
            wait_cnt  <= wait_cnt - 4'd1;
        end
    end

    // Offset-based range check avoids overflow of BASE_ADDR + span.
    assign offset   = lat_addr - BASE_ADDR;
    assign in_range = (lat_addr >= BASE_ADDR) && (offset < REG_SPAN);
    assign aligned  = (lat_addr & ALIGN_MASK) == '0;
    assign reg_idx  = IDX_WIDTH'(offset >> OFFS_BITS);

`ifdef APB_SLAVE_PROT_CHECK_EN
    logic unused_prot;
    assign unused_prot = ^{lat_prot[2], lat_prot[0]};

    // Register 0 is secure: pprot[1] marks a non-secure access.
    always_comb begin
        err = NO_ERROR;
        if (!in_range || !aligned)              err = SLAVE_ERROR;
        else if (reg_idx == '0 && lat_prot[1])  err = SLAVE_ERROR;
    end
`else
    logic unused_prot;
    assign unused_prot = ^lat_prot;

    always_comb begin
        err = NO_ERROR;
        if (!in_range || !aligned) err = SLAVE_ERROR;
    end
`endif

    assign wr_en = (state == ACCESS) && (lat_write == WRITE) && (err == NO_ERROR);

    apb_slave_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NO_OF_REGS (NO_OF_REGS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_regfile (
        .pclk    (pclk),
        .preset  (preset),
        .wr_en   (wr_en),
        .wr_idx  (reg_idx),
        .wr_data (lat_wdata),
        .wr_strb (lat_strb),
        .rd_idx  (reg_idx),
        .rd_data (rd_data)
    );

    // Outputs decode the registered state only; a read sees the register
    // contents before any commit on the closing edge.
    assign pready  = (state == ACCESS);
    assign pslverr = (state == ACCESS) && (err == SLAVE_ERROR);
    assign prdata  = ((state == ACCESS) && (lat_write == READ) && (err == NO_ERROR))
                     ? rd_data : '0;

endmodule

// File: tb/tb_apb_slave_responder.sv
// Directed bench for apb_slave_responder: hand-computed vectors for reads,
// writes, wait states, strobes, decode errors, aborts and reset mid-transfer.
module tb_apb_slave_responder;

    logic        pclk;
    logic        preset;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [3:0]  cfg_wait_states;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    int errors = 0;
    int checks = 0;

    apb_slave_responder dut (
        .pclk            (pclk),
        .preset          (preset),
        .pselx           (pselx),
        .penable         (penable),
        .pwrite          (pwrite),
        .paddr           (paddr),
        .pwdata          (pwdata),
        .pstrb           (pstrb),
        .pprot           (pprot),
        .cfg_wait_states (cfg_wait_states),
        .pready          (pready),
        .pslverr         (pslverr),
        .prdata          (prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Runs one transfer starting at a falling edge. cycles counts from the
    // SETUP cycle (first penable cycle) up to and including the pready cycle;
    // -1 means pready never came within the budget.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [2:0] prot, input logic [3:0] ws,
                            output logic [31:0] rdata, output logic err, output int cycles);
        pselx = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = data; pstrb = strb; pprot = prot; cfg_wait_states = ws;
        @(negedge pclk);
        penable = 1'b1;
        cycles = 0; rdata = '0; err = 1'b0;
        forever begin
            #1;
            cycles++;
            if (pready) begin
                rdata = prdata;
                err   = pslverr;
                break;
            end
            if (cycles > 40) begin
                cycles = -1;
                break;
            end
            @(negedge pclk);
        end
        @(negedge pclk);
        pselx = 1'b0; penable = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [2:0] prot, input logic [3:0] ws,
                            input logic exp_err, input int exp_cycles);
        logic [31:0] rd;
        logic        er;
        int          cyc;
        apb_xfer(1'b1, addr, data, strb, prot, ws, rd, er, cyc);
        check({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
        check({tag, "_pslverr"}, {31'd0, er}, {31'd0, exp_err});
        check({tag, "_prdata"}, rd, 32'h0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [2:0] prot,
                           input logic [3:0] ws, input logic [31:0] exp_data,
                           input logic exp_err, input int exp_cycles);
        logic [31:0] rd;
        logic        er;
        int          cyc;
        apb_xfer(1'b0, addr, 32'h0, 4'h0, prot, ws, rd, er, cyc);
        check({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
        check({tag, "_pslverr"}, {31'd0, er}, {31'd0, exp_err});
        check({tag, "_prdata"}, rd, exp_data);
        #1;
        check({tag, "_idle_prdata"}, prdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        preset = 1'b1; pselx = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0; cfg_wait_states = '0;
        #3;
        check("reset_pready", {31'd0, pready}, 32'h0);
        check("reset_pslverr", {31'd0, pslverr}, 32'h0);
        check("reset_prdata", prdata, 32'h0);
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);

        // Basic write/read, zero wait states: pready on the second cycle.
        do_write("wr_04", 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 3'b000, 4'd0, 1'b0, 2);
        do_read ("rd_04", 32'h0000_0004, 3'b000, 4'd0, 32'hDEAD_BEEF, 1'b0, 2);

        // Wait states: N waits give N+2 cycles.
        do_read ("rd_00_ws3", 32'h0000_0000, 3'b000, 4'd3, 32'h0, 1'b0, 5);
        do_read ("rd_04_ws1", 32'h0000_0004, 3'b000, 4'd1, 32'hDEAD_BEEF, 1'b0, 3);

        // Byte strobes: lanes 0 and 2 only.
        do_write("wr_08_all", 32'h0000_0008, 32'hFFFF_FFFF, 4'hF, 3'b000, 4'd0, 1'b0, 2);
        do_write("wr_08_strb", 32'h0000_0008, 32'h1122_3344, 4'b0101, 3'b000, 4'd2, 1'b0, 4);
        do_read ("rd_08", 32'h0000_0008, 3'b000, 4'd0, 32'hFF22_FF44, 1'b0, 2);

        // Decode errors: past the end and misaligned; nothing may change.
        do_write("wr_40_err", 32'h0000_0040, 32'h1234_5678, 4'hF, 3'b000, 4'd0, 1'b1, 2);
        do_write("wr_02_err", 32'h0000_0002, 32'h8765_4321, 4'hF, 3'b000, 4'd0, 1'b1, 2);
        do_read ("rd_00_after_err", 32'h0000_0000, 3'b000, 4'd0, 32'h0, 1'b0, 2);
        do_read ("rd_04_after_err", 32'h0000_0004, 3'b000, 4'd0, 32'hDEAD_BEEF, 1'b0, 2);
        do_read ("rd_08_after_err", 32'h0000_0008, 3'b000, 4'd0, 32'hFF22_FF44, 1'b0, 2);
        do_read ("rd_40_err", 32'h0000_0040, 3'b000, 4'd0, 32'h0, 1'b1, 2);

        // Last valid register.
        do_write("wr_3c", 32'h0000_003C, 32'hA5A5_A5A5, 4'hF, 3'b000, 4'd0, 1'b0, 2);
        do_read ("rd_3c", 32'h0000_003C, 3'b000, 4'd0, 32'hA5A5_A5A5, 1'b0, 2);

        // Abort: pselx drops while the FSM is in SETUP.
        pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_000C;
        pwdata = 32'h0000_0055; pstrb = 4'hF; pprot = 3'b000; cfg_wait_states = 4'd0;
        @(negedge pclk);
        pselx = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge pclk);
            #1;
            if (pready) seen++;
        end
        check("abort_no_pready", 32'(seen), 32'h0);
        do_read ("rd_0c_after_abort", 32'h0000_000C, 3'b000, 4'd0, 32'h0, 1'b0, 2);

`ifdef APB_SLAVE_PROT_CHECK_EN
        do_write("prot_wr_ns", 32'h0000_0000, 32'h1234_5678, 4'hF, 3'b010, 4'd0, 1'b1, 2);
        do_read ("prot_rd_s_unchanged", 32'h0000_0000, 3'b000, 4'd0, 32'h0, 1'b0, 2);
        do_write("prot_wr_s", 32'h0000_0000, 32'h1234_5678, 4'hF, 3'b000, 4'd0, 1'b0, 2);
        do_read ("prot_rd_s", 32'h0000_0000, 3'b000, 4'd0, 32'h1234_5678, 1'b0, 2);
        do_read ("prot_rd_ns", 32'h0000_0000, 3'b010, 4'd0, 32'h0, 1'b1, 2);
        do_read ("prot_rd_ns_reg1", 32'h0000_0004, 3'b010, 4'd0, 32'hDEAD_BEEF, 1'b0, 2);
`else
        do_write("prot_ignored_wr", 32'h0000_0000, 32'h1234_5678, 4'hF, 3'b010, 4'd0, 1'b0, 2);
        do_read ("prot_ignored_rd", 32'h0000_0000, 3'b010, 4'd0, 32'h1234_5678, 1'b0, 2);
`endif

        // Reset pulsed in WAIT of a write to 0x0; the master keeps driving an
        // access phase, which the responder must ignore from IDLE.
        pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_0000;
        pwdata = 32'hCAFE_F00D; pstrb = 4'hF; pprot = 3'b000; cfg_wait_states = 4'd3;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        #2 preset = 1'b1;
        #1 check("rst_mid_pready", {31'd0, pready}, 32'h0);
        #1 preset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge pclk);
            #1;
            if (pready) seen++;
        end
        check("rst_no_pready", 32'(seen), 32'h0);
        @(negedge pclk);
        pselx = 1'b0; penable = 1'b0;
        @(negedge pclk);
        do_read ("rst_rd_00", 32'h0000_0000, 3'b000, 4'd0, 32'h0, 1'b0, 2);
        do_read ("rst_rd_04", 32'h0000_0004, 3'b000, 4'd0, 32'h0, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
